gb_apu_pulse_ctrl: RTL and testbench
====================================

# gb_apu_pulse_ctrl

Register front-end and sequencer for the two pulse channels (CH1 with sweep, CH2 without). It decodes CPU writes/reads to NR10–NR14, NR21–NR24 and NR52. It drives the configuration and trigger inputs of both pulse channel instances, and runs the 512 Hz frame sequencer that produces the length, envelope and sweep strobes. It sits between the CPU bus and the pulse channels.

## Interface
- `TRIGGER_CYCLES`, default 2: cycles `chN_start` is held high per trigger (≥1).
- `clk`  in  1  CPU clock.
- `reset`  in  1  asynchronous, active-high reset.
- `div_apu_bit`  in  1  DIV-APU source bit (DIV bit 4; bit 5 in double speed, selected upstream).
- `cpu_wr`  in  1  write strobe, one cycle per access.
- `cpu_rd`  in  1  read strobe.
- `cpu_addr`  in  8  low byte of 0xFFxx.
- `cpu_wdata`  in  8  write data.
- `cpu_rdata`  out  8  read data, registered.
- `ch1_enable`, `ch2_enable`  in  1  channel `enable` outputs, fed back for NR52 status.
- `clk_length_ctr`, `clk_vol_env`, `clk_sweep`  out  1  one-cycle strobes in the `clk` domain.
- `ch1_sweep_time` 3, `ch1_sweep_decreasing` 1, `ch1_num_sweep_shifts` 3  out: from NR10.
- `chN_wave_duty` 2, `chN_length` 6  out: from NR11/NR21.
- `chN_initial_volume` 4, `chN_envelope_increasing` 1, `chN_num_envelope_sweeps` 3  out: from NR12/NR22.
- `chN_frequency` 11  out: {NRx4[2:0], NRx3}.
- `chN_single` 1  out: NRx4[6].
- `chN_start` 1  out: trigger level.

## Operation
- **Address map:** 0x10 NR10, 0x11 NR11, 0x12 NR12, 0x13 NR13, 0x14 NR14, 0x16 NR21, 0x17 NR22, 0x18 NR23, 0x19 NR24, 0x26 NR52.
  - Writes to other addresses are ignored.
  - Stored fields: NR10[6:0]; NRx4[6] and [2:0]; other registers full 8 bits. NRx4[7] (trigger) is never stored.
- **Read-back masks:** ORed onto the stored value.
  - NR10 |0x80; NR11/NR21 |0x3F; NR12/NR22 |0x00; NR13/NR23 read 0xFF; NR14/NR24 |0xBF.
  - NR52 = {power, 3'b111, 2'b00, ch2_enable, ch1_enable}.
  - Unmapped addresses read 0xFF.
- **Power (NR52[7]):**
  - Writing 0 clears every channel register and the trigger FSMs, and resets the sequencer step to 0.
  - While off, writes to any address other than 0x26 are ignored, and no strobes or triggers are issued.
  - Writing 1 while off restarts the sequencer at step 0.
- **Frame sequencer:**
  - `div_apu_bit` is registered; a falling edge (prev 1, now 0) is a tick.
  - On each tick, `step` (3-bit) increments mod 8.
  - Strobes are issued for the pre-increment step: length on steps 0, 2, 4, 6; sweep on 2, 6; envelope on 7.
- **Trigger FSM, one per channel, states IDLE/HIGH/GAP:**
  - A write to NRx4 with bit7=1 while powered moves IDLE→HIGH and loads a counter with `TRIGGER_CYCLES`.
  - HIGH: `chN_start`=1; counter decrements; at 1 → IDLE, or → GAP if a trigger is pending.
  - A trigger write during HIGH or GAP sets the pending flag (multiple writes collapse to one).
  - GAP: `chN_start`=0 for exactly one cycle, then → HIGH with the counter reloaded and pending cleared. This guarantees the downstream edge detector sees a new rising edge.

## Timing
- Write in cycle N → register fields and `chN_start`=1 visible from N+1. The frequency of a triggering NRx4 write is therefore valid in the same cycle `start` rises.
- Read in cycle N → `cpu_rdata` valid in N+1 and held until the next read. Simultaneous read and write to the same address returns the pre-write value.
- Tick detected in cycle N (div sampled 0 after 1) → strobe high in cycle N+1 only.
- Power-off write in cycle N → all config outputs, `chN_start` and strobes are 0 from N+1. A tick in the same cycle is discarded.
- **Reset values:** all registers 0, power=0, step=0, FSMs IDLE, all outputs 0, `cpu_rdata`=0x00.
- **Reset mid-trigger:** `start` drops immediately (asynchronous).

## Structure
- `gb_apu_pkg` holds:
  - the register address localparams (NR10…NR52);
  - the read-mask constants;
  - the `trig_state_t` enum {IDLE, HIGH, GAP};
  - the step-to-strobe decode function.
- Sub-module `gb_apu_frame_sequencer` (clk, reset, power, div_apu_bit → three strobes, step). The register decode and the two trigger FSMs stay in the top module.

## Test plan
- Reset, then write 0x80 to 0x26, then pulse `div_apu_bit` 8 times → length strobes on ticks 1, 3, 5, 7; sweep on ticks 3, 7; envelope on tick 8; each strobe exactly 1 cycle wide.
- Power on; write 0x13=0x56, 0x14=0xC3 → `ch1_frequency`=0x356, `ch1_single`=1, `ch1_start` high for 2 cycles from N+1; reading 0x14 returns 0xFF.
- Trigger 0x19 twice, one cycle apart → `ch2_start` 1,1,0,1,1 (GAP of one cycle, then a second HIGH).
- Write 0x12=0xA5, then 0x26=0x00 → `ch1_initial_volume` 0xA→0; a write of 0x12=0xFF while off is ignored; reading 0x12 returns 0x00.
- Reading NR52 with power on, ch1_enable=1, ch2_enable=0 → 0xF1; reading 0x15 → 0xFF; reading NR10 after writing 0x00 → 0x80.
- Assert reset during HIGH → `ch1_start`=0 asynchronously; no `start` after release until a new trigger write.

Source files
------------

// File: rtl/gb_apu_pkg.sv
// gb_apu_pkg: register map, read masks, trigger states and frame-step decode for the pulse front-end
package gb_apu_pkg;
    localparam logic [7:0] ADDR_NR10 = 8'h10;
    localparam logic [7:0] ADDR_NR11 = 8'h11;
    localparam logic [7:0] ADDR_NR12 = 8'h12;
    localparam logic [7:0] ADDR_NR13 = 8'h13;
    localparam logic [7:0] ADDR_NR14 = 8'h14;
    localparam logic [7:0] ADDR_NR21 = 8'h16;
    localparam logic [7:0] ADDR_NR22 = 8'h17;
    localparam logic [7:0] ADDR_NR23 = 8'h18;
    localparam logic [7:0] ADDR_NR24 = 8'h19;
    localparam logic [7:0] ADDR_NR52 = 8'h26;

    localparam logic [7:0] MASK_NR10 = 8'h80;
    localparam logic [7:0] MASK_NRX1 = 8'h3F;
    localparam logic [7:0] MASK_NRX2 = 8'h00;
    localparam logic [7:0] MASK_NRX3 = 8'hFF;
    localparam logic [7:0] MASK_NRX4 = 8'hBF;

    typedef enum logic [1:0] {IDLE, HIGH, GAP} trig_state_t;

    // returns {length, sweep, envelope} strobes for the step being left
    function automatic logic [2:0] step_strobes(input logic [2:0] step);
        return {~step[0], step[1] & ~step[0], &step};
    endfunction
endpackage

// File: rtl/gb_apu_frame_sequencer.sv
// gb_apu_frame_sequencer: 512 Hz step counter driven by falling edges of the DIV-APU bit
module gb_apu_frame_sequencer
    import gb_apu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       power,
    input  logic       div_apu_bit,
    output logic       clk_length_ctr,
    output logic       clk_vol_env,
    output logic       clk_sweep,
    output logic [2:0] step
);
    logic div_q;
    logic tick;

    assign tick = div_q & ~div_apu_bit;

    // power here is the next-cycle power, so a power-off write swallows a coincident tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q <= 1'b0;
            step <= 3'd0;
            {clk_length_ctr, clk_sweep, clk_vol_env} <= 3'b000;
        end else begin
            div_q <= div_apu_bit;
            step <= !power ? 3'd0 : step + 3'(tick);
            {clk_length_ctr, clk_sweep, clk_vol_env} <= (tick && power) ? step_strobes(step) : 3'b000;
        end
    end
endmodule

// File: rtl/gb_apu_pulse_ctrl.sv
// gb_apu_pulse_ctrl: CPU register front-end, trigger sequencing and frame sequencer for pulse CH1/CH2
module gb_apu_pulse_ctrl
    import gb_apu_pkg::*;
#(
    parameter int unsigned TRIGGER_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        div_apu_bit,
    input  logic        cpu_wr,
    input  logic        cpu_rd,
    input  logic [7:0]  cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    input  logic        ch1_enable,
    input  logic        ch2_enable,
    output logic        clk_length_ctr,
    output logic        clk_vol_env,
    output logic        clk_sweep,
    output logic [2:0]  ch1_sweep_time,
    output logic        ch1_sweep_decreasing,
    output logic [2:0]  ch1_num_sweep_shifts,
    output logic [1:0]  ch1_wave_duty,
    output logic [5:0]  ch1_length,
    output logic [3:0]  ch1_initial_volume,
    output logic        ch1_envelope_increasing,
    output logic [2:0]  ch1_num_envelope_sweeps,
    output logic [10:0] ch1_frequency,
    output logic        ch1_single,
    output logic        ch1_start,
    output logic [1:0]  ch2_wave_duty,
    output logic [5:0]  ch2_length,
    output logic [3:0]  ch2_initial_volume,
    output logic        ch2_envelope_increasing,
    output logic [2:0]  ch2_num_envelope_sweeps,
    output logic [10:0] ch2_frequency,
    output logic        ch2_single,
    output logic        ch2_start
);
    localparam int CW = $clog2(TRIGGER_CYCLES + 1);
    localparam logic [CW-1:0] TC = CW'(TRIGGER_CYCLES);

    logic [7:0] nr10, nr11, nr12, nr13, nr14, nr21, nr22, nr23, nr24;
    logic power, power_n, power_off, wr_pw;
    logic [7:0] rd_val;
    logic [1:0] trig;
    trig_state_t state [2];
    trig_state_t state_n [2];
    logic [CW-1:0] cnt [2];
    logic [CW-1:0] cnt_n [2];
    logic [1:0] pend, pend_n;

    assign power_off = cpu_wr && cpu_addr == ADDR_NR52 && !cpu_wdata[7];
    assign power_n = (cpu_wr && cpu_addr == ADDR_NR52) ? cpu_wdata[7] : power;
    assign wr_pw = cpu_wr && power;
    assign trig = {wr_pw && cpu_addr == ADDR_NR24 && cpu_wdata[7],
                   wr_pw && cpu_addr == ADDR_NR14 && cpu_wdata[7]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            power <= 1'b0;
            {nr10, nr11, nr12, nr13, nr14, nr21, nr22, nr23, nr24} <= '0;
        end else if (cpu_wr && cpu_addr == ADDR_NR52) begin
            power <= cpu_wdata[7];
            if (!cpu_wdata[7]) {nr10, nr11, nr12, nr13, nr14, nr21, nr22, nr23, nr24} <= '0;
        end else if (wr_pw) begin
            case (cpu_addr)
                ADDR_NR10: nr10 <= cpu_wdata & 8'h7F;
                ADDR_NR11: nr11 <= cpu_wdata;
                ADDR_NR12: nr12 <= cpu_wdata;
                ADDR_NR13: nr13 <= cpu_wdata;
                ADDR_NR14: nr14 <= cpu_wdata & 8'h47;
                ADDR_NR21: nr21 <= cpu_wdata;
                ADDR_NR22: nr22 <= cpu_wdata;
                ADDR_NR23: nr23 <= cpu_wdata;
                ADDR_NR24: nr24 <= cpu_wdata & 8'h47;
                default: ;
            endcase
        end
    end

    always_comb begin
        case (cpu_addr)
            ADDR_NR10: rd_val = nr10 | MASK_NR10;
            ADDR_NR11: rd_val = nr11 | MASK_NRX1;
            ADDR_NR12: rd_val = nr12 | MASK_NRX2;
            ADDR_NR13: rd_val = nr13 | MASK_NRX3;
            ADDR_NR14: rd_val = nr14 | MASK_NRX4;
            ADDR_NR21: rd_val = nr21 | MASK_NRX1;
            ADDR_NR22: rd_val = nr22 | MASK_NRX2;
            ADDR_NR23: rd_val = nr23 | MASK_NRX3;
            ADDR_NR24: rd_val = nr24 | MASK_NRX4;
            ADDR_NR52: rd_val = {power, 3'b111, 2'b00, ch2_enable, ch1_enable};
            default:   rd_val = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cpu_rdata <= 8'h00;
        else if (cpu_rd) cpu_rdata <= rd_val;
    end

    // a trigger arriving while HIGH forces a one-cycle GAP so the channel sees a fresh rising edge
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            state_n[c] = state[c];
            cnt_n[c] = cnt[c];
            pend_n[c] = pend[c];
            case (state[c])
                IDLE: if (trig[c]) begin
                    state_n[c] = HIGH;
                    cnt_n[c] = TC;
                end
                HIGH: begin
                    cnt_n[c] = cnt[c] - CW'(1);
                    pend_n[c] = pend[c] | trig[c];
                    if (cnt[c] == CW'(1)) state_n[c] = (pend[c] | trig[c]) ? GAP : IDLE;
                end
                GAP: begin
                    state_n[c] = HIGH;
                    cnt_n[c] = TC;
                    pend_n[c] = 1'b0;
                end
                default: state_n[c] = IDLE;
            endcase
            if (power_off) begin
                state_n[c] = IDLE;
                cnt_n[c] = '0;
                pend_n[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                state[c] <= IDLE;
                cnt[c] <= '0;
            end
            pend <= 2'b00;
        end else begin
            for (int c = 0; c < 2; c++) begin
                state[c] <= state_n[c];
                cnt[c] <= cnt_n[c];
            end
            pend <= pend_n;
        end
    end

    assign ch1_start = state[0] == HIGH;
    assign ch2_start = state[1] == HIGH;

    assign {ch1_sweep_time, ch1_sweep_decreasing, ch1_num_sweep_shifts} = nr10[6:0];
    assign {ch1_wave_duty, ch1_length} = nr11;
    assign {ch1_initial_volume, ch1_envelope_increasing, ch1_num_envelope_sweeps} = nr12;
    assign ch1_frequency = {nr14[2:0], nr13};
    assign ch1_single = nr14[6];
    assign {ch2_wave_duty, ch2_length} = nr21;
    assign {ch2_initial_volume, ch2_envelope_increasing, ch2_num_envelope_sweeps} = nr22;
    assign ch2_frequency = {nr24[2:0], nr23};
    assign ch2_single = nr24[6];

    gb_apu_frame_sequencer u_seq (
        .clk(clk),
        .reset(reset),
        .power(power_n),
        .div_apu_bit(div_apu_bit),
        .clk_length_ctr(clk_length_ctr),
        .clk_vol_env(clk_vol_env),
        .clk_sweep(clk_sweep),
        .step()
    );
endmodule

// File: tb/tb_gb_apu_pulse_ctrl.sv
// tb_gb_apu_pulse_ctrl: directed checks of register access, power, triggers and frame strobes
module tb_gb_apu_pulse_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic div_apu_bit = 1'b0;
    logic cpu_wr = 1'b0;
    logic cpu_rd = 1'b0;
    logic [7:0] cpu_addr = 8'h00;
    logic [7:0] cpu_wdata = 8'h00;
    logic [7:0] cpu_rdata;
    logic ch1_enable = 1'b0;
    logic ch2_enable = 1'b0;
    logic clk_length_ctr, clk_vol_env, clk_sweep;
    logic [2:0] ch1_sweep_time, ch1_num_sweep_shifts, ch1_num_envelope_sweeps, ch2_num_envelope_sweeps;
    logic ch1_sweep_decreasing, ch1_envelope_increasing, ch2_envelope_increasing;
    logic [1:0] ch1_wave_duty, ch2_wave_duty;
    logic [5:0] ch1_length, ch2_length;
    logic [3:0] ch1_initial_volume, ch2_initial_volume;
    logic [10:0] ch1_frequency, ch2_frequency;
    logic ch1_single, ch2_single, ch1_start, ch2_start;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    gb_apu_pulse_ctrl #(.TRIGGER_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .div_apu_bit(div_apu_bit),
        .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .ch1_enable(ch1_enable), .ch2_enable(ch2_enable),
        .clk_length_ctr(clk_length_ctr), .clk_vol_env(clk_vol_env), .clk_sweep(clk_sweep),
        .ch1_sweep_time(ch1_sweep_time), .ch1_sweep_decreasing(ch1_sweep_decreasing),
        .ch1_num_sweep_shifts(ch1_num_sweep_shifts),
        .ch1_wave_duty(ch1_wave_duty), .ch1_length(ch1_length),
        .ch1_initial_volume(ch1_initial_volume), .ch1_envelope_increasing(ch1_envelope_increasing),
        .ch1_num_envelope_sweeps(ch1_num_envelope_sweeps),
        .ch1_frequency(ch1_frequency), .ch1_single(ch1_single), .ch1_start(ch1_start),
        .ch2_wave_duty(ch2_wave_duty), .ch2_length(ch2_length),
        .ch2_initial_volume(ch2_initial_volume), .ch2_envelope_increasing(ch2_envelope_increasing),
        .ch2_num_envelope_sweeps(ch2_num_envelope_sweeps),
        .ch2_frequency(ch2_frequency), .ch2_single(ch2_single), .ch2_start(ch2_start)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        cpu_wr = 1'b1;
        cpu_addr = a;
        cpu_wdata = d;
        @(negedge clk);
        cpu_wr = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        cpu_rd = 1'b1;
        cpu_addr = a;
        @(negedge clk);
        cpu_rd = 1'b0;
        d = cpu_rdata;
    endtask

    // one div falling edge; counts cycles each strobe is seen high
    task automatic pulse_div(output int nl, output int ns, output int ne);
        nl = 0; ns = 0; ne = 0;
        @(negedge clk);
        div_apu_bit = 1'b1;
        repeat (3) @(negedge clk);
        div_apu_bit = 1'b0;
        repeat (5) begin
            @(negedge clk);
            nl += int'(clk_length_ctr);
            ns += int'(clk_sweep);
            ne += int'(clk_vol_env);
        end
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] exp_len, exp_sw, exp_env;
        logic [5:0] exp_st;
        int nl, ns, ne, hits;

        repeat (2) @(negedge clk);
        check("rst_rdata", cpu_rdata, 8'h00);
        check("rst_start", {ch1_start, ch2_start}, 2'b00);
        check("rst_strobes", {clk_length_ctr, clk_sweep, clk_vol_env}, 3'b000);
        check("rst_freq", ch1_frequency, 11'h000);
        reset = 1'b0;

        // no strobes while unpowered
        pulse_div(nl, ns, ne);
        check("off_tick", nl + ns + ne, 0);

        wr(8'h26, 8'h80);
        rd(8'h26, d);
        check("nr52_on", d, 8'hF0);

        exp_len = 8'b0101_0101;
        exp_sw  = 8'b0100_0100;
        exp_env = 8'b1000_0000;
        for (int i = 0; i < 8; i++) begin
            pulse_div(nl, ns, ne);
            check($sformatf("len_t%0d", i + 1), nl, int'(exp_len[i]));
            check($sformatf("sweep_t%0d", i + 1), ns, int'(exp_sw[i]));
            check($sformatf("env_t%0d", i + 1), ne, int'(exp_env[i]));
        end

        wr(8'h13, 8'h56);
        wr(8'h14, 8'hC3);
        check("ch1_freq", ch1_frequency, 11'h356);
        check("ch1_single", ch1_single, 1'b1);
        check("ch1_start_c1", ch1_start, 1'b1);
        @(negedge clk);
        check("ch1_start_c2", ch1_start, 1'b1);
        @(negedge clk);
        check("ch1_start_c3", ch1_start, 1'b0);
        rd(8'h14, d);
        check("rd_nr14", d, 8'hFF);

        exp_st = 6'b011011;
        @(negedge clk);
        cpu_wr = 1'b1; cpu_addr = 8'h19; cpu_wdata = 8'h80;
        @(negedge clk);
        cpu_wr = 1'b0;
        check("ch2_seq0", ch2_start, exp_st[0]);
        @(negedge clk);
        check("ch2_seq1", ch2_start, exp_st[1]);
        cpu_wr = 1'b1; cpu_addr = 8'h19; cpu_wdata = 8'h80;
        for (int i = 2; i < 6; i++) begin
            @(negedge clk);
            cpu_wr = 1'b0;
            check($sformatf("ch2_seq%0d", i), ch2_start, exp_st[i]);
        end

        wr(8'h11, 8'h80);
        rd(8'h11, d);
        check("rd_nr11", d, 8'hBF);
        rd(8'h13, d);
        check("rd_nr13", d, 8'hFF);
        wr(8'h12, 8'h33);
        @(negedge clk);
        cpu_wr = 1'b1; cpu_rd = 1'b1; cpu_addr = 8'h12; cpu_wdata = 8'h44;
        @(negedge clk);
        cpu_wr = 1'b0; cpu_rd = 1'b0;
        check("rd_wr_same", cpu_rdata, 8'h33);
        rd(8'h12, d);
        check("rd_after_wr", d, 8'h44);

        wr(8'h12, 8'hA5);
        check("vol_a", ch1_initial_volume, 4'hA);
        wr(8'h26, 8'h00);
        check("vol_off", ch1_initial_volume, 4'h0);
        check("freq_off", ch1_frequency, 11'h000);
        wr(8'h12, 8'hFF);
        check("vol_ign", ch1_initial_volume, 4'h0);
        rd(8'h12, d);
        check("rd_nr12_off", d, 8'h00);
        rd(8'h26, d);
        check("nr52_off", d, 8'h70);
        wr(8'h14, 8'h80);
        check("trig_off", ch1_start, 1'b0);

        // re-power restarts at step 0: first tick is a length-only step
        wr(8'h26, 8'h80);
        pulse_div(nl, ns, ne);
        check("restart_len", nl, 1);
        check("restart_sw", ns, 0);

        ch1_enable = 1'b1;
        rd(8'h26, d);
        check("nr52_en", d, 8'hF1);
        ch1_enable = 1'b0;
        rd(8'h15, d);
        check("rd_unmapped", d, 8'hFF);
        wr(8'h10, 8'h00);
        rd(8'h10, d);
        check("rd_nr10", d, 8'h80);
        wr(8'h10, 8'hFF);
        check("nr10_fields", {ch1_sweep_time, ch1_sweep_decreasing, ch1_num_sweep_shifts}, 7'h7F);

        wr(8'h14, 8'h80);
        check("pre_rst_start", ch1_start, 1'b1);
        #2 reset = 1'b1;
        #1 check("async_rst_start", ch1_start, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        hits = 0;
        repeat (6) begin
            @(negedge clk);
            hits += int'(ch1_start);
        end
        check("no_start_after_rst", hits, 0);
        check("rst_rdata2", cpu_rdata, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
